// File: rtl/accel_cmd_responder.sv
// Accelerator endpoint of the COP command/response interface: CSR accesses
// and a 4-cycle signed int8 dot product, one response per accepted command.
module accel_cmd_responder #(
    parameter int ID_WIDTH        = 12,
    parameter int REQ_DATA_WIDTH  = 256,
    parameter int RESP_DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_b,
    // Handshake: a command transfers on a rising clk edge where
    // accel_cmd_valid && accel_cmd_ready; the response channel has no ready.
    input  logic                       accel_cmd_valid,
    output logic                       accel_cmd_ready,
    input  logic [4:0]                 accel_cmd_opcode,
    input  logic [7:0]                 accel_cmd_hint,
    input  logic [ID_WIDTH-1:0]        accel_cmd_id,
    input  logic [REQ_DATA_WIDTH-1:0]  accel_cmd_data,
    output logic                       accel_resp_valid,
    output logic [ID_WIDTH-1:0]        accel_resp_id,
    output logic [RESP_DATA_WIDTH-1:0] accel_resp_data,
    output logic [0:0]                 dbg_state
);

    localparam logic [4:0] OP_NOP    = 5'h00;
    localparam logic [4:0] OP_CSR_WR = 5'h01;
    localparam logic [4:0] OP_CSR_RD = 5'h02;
    localparam logic [4:0] OP_DOT8   = 5'h03;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DOT  = 1'b1;

    logic [0:0]          state;
    logic [1:0]          k;
    logic [127:0]        op_a;
    logic [127:0]        op_b;
    logic [63:0]         acc;
    logic [ID_WIDTH-1:0] op_id;
    logic [63:0]         csr [8];
    logic [2:0]          csr_idx;
    logic                cmd_fire;

    logic signed [7:0]   lane_a;
    logic signed [7:0]   lane_b;
    logic signed [15:0]  lane_prod;
    logic signed [63:0]  dot_partial;

    logic                unused_hint;

    assign cmd_fire    = accel_cmd_valid && accel_cmd_ready;
    assign csr_idx     = accel_cmd_hint[2:0];
    assign dbg_state   = state;
    assign unused_hint = ^accel_cmd_hint[7:3];

    // Sum of the four lanes selected by k: lanes 4k..4k+3.
    always_comb begin
        dot_partial = '0;
        lane_a      = '0;
        lane_b      = '0;
        lane_prod   = '0;
        for (int j = 0; j < 4; j++) begin
            lane_a      = op_a[(int'(k) * 4 + j) * 8 +: 8];
            lane_b      = op_b[(int'(k) * 4 + j) * 8 +: 8];
            lane_prod   = lane_a * lane_b;
            dot_partial = dot_partial + 64'(lane_prod);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state            <= ST_IDLE;
            k                <= '0;
            op_a             <= '0;
            op_b             <= '0;
            acc              <= '0;
            op_id            <= '0;
            accel_cmd_ready  <= 1'b0;
            accel_resp_valid <= 1'b0;
            accel_resp_id    <= '0;
            accel_resp_data  <= '0;
            for (int i = 0; i < 8; i++) begin
                csr[i] <= '0;
            end
        end else begin
            accel_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    accel_cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        if (accel_cmd_opcode == OP_DOT8) begin
                            state           <= ST_DOT;
                            accel_cmd_ready <= 1'b0;
                            k               <= '0;
                            acc             <= '0;
                            op_a            <= accel_cmd_data[127:0];
                            op_b            <= accel_cmd_data[255:128];
                            op_id           <= accel_cmd_id;
                        end else begin
                            accel_resp_valid <= 1'b1;
                            accel_resp_id    <= accel_cmd_id;
                            csr[7]           <= csr[7] + 64'd1;
                            case (accel_cmd_opcode)
                                OP_NOP: accel_resp_data <= '0;
                                OP_CSR_WR: begin
                                    accel_resp_data <= csr[csr_idx];
                                    // csr[7] is the read-only completion counter
                                    if (csr_idx != 3'd7) begin
                                        csr[csr_idx] <= accel_cmd_data[63:0];
                                    end
                                end
                                OP_CSR_RD: accel_resp_data <= csr[csr_idx];
                                default:   accel_resp_data <= '1;
                            endcase
                        end
                    end
                end
                ST_DOT: begin
                    k   <= k + 2'd1;
                    acc <= acc + dot_partial;
                    if (k == 2'd3) begin
                        state            <= ST_IDLE;
                        accel_cmd_ready  <= 1'b1;
                        accel_resp_valid <= 1'b1;
                        accel_resp_id    <= op_id;
                        accel_resp_data  <= acc + dot_partial;
                        csr[7]           <= csr[7] + 64'd1;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    accel_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_cmd_responder.sv
// Randomized scoreboard bench for accel_cmd_responder against a
// lane-by-lane reference model of the command set.
module tb_accel_cmd_responder;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         accel_cmd_valid;
    logic         accel_cmd_ready;
    logic [4:0]   accel_cmd_opcode;
    logic [7:0]   accel_cmd_hint;
    logic [11:0]  accel_cmd_id;
    logic [255:0] accel_cmd_data;
    logic         accel_resp_valid;
    logic [11:0]  accel_resp_id;
    logic [63:0]  accel_resp_data;
    logic [0:0]   dbg_state;

    always #5 clk = ~clk;

    accel_cmd_responder dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .accel_cmd_valid  (accel_cmd_valid),
        .accel_cmd_ready  (accel_cmd_ready),
        .accel_cmd_opcode (accel_cmd_opcode),
        .accel_cmd_hint   (accel_cmd_hint),
        .accel_cmd_id     (accel_cmd_id),
        .accel_cmd_data   (accel_cmd_data),
        .accel_resp_valid (accel_resp_valid),
        .accel_resp_id    (accel_resp_id),
        .accel_resp_data  (accel_resp_data),
        .dbg_state        (dbg_state)
    );

    typedef struct {
        logic [11:0] id;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] m_csr [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dot_ref(input logic [255:0] d);
        longint s = 0;
        for (int i = 0; i < 16; i++) begin
            s += longint'($signed(d[8*i +: 8])) * longint'($signed(d[128 + 8*i +: 8]));
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_csr[i] = '0;
    endtask

    // Expected result and latency of a command; updates the model CSRs.
    task automatic model_cmd(input logic [4:0] op, input logic [7:0] hint,
                             input logic [255:0] d, output logic [63:0] r, output int lat);
        int h = {29'd0, hint[2:0]};
        lat = 1;
        case (op)
            5'h00: r = '0;
            5'h01: begin
                r = m_csr[h];
                if (h != 7) m_csr[h] = d[63:0];
            end
            5'h02: r = m_csr[h];
            5'h03: begin
                r   = dot_ref(d);
                lat = 5;
            end
            default: r = '1;
        endcase
        m_csr[7] = m_csr[7] + 64'd1;
    endtask

    task automatic send(input logic [4:0] op, input logic [7:0] hint, input logic [11:0] id,
                        input logic [255:0] d, output int acc_cyc, output int waits);
        logic [63:0] r;
        int          lat;
        @(negedge clk);
        accel_cmd_valid  = 1'b1;
        accel_cmd_opcode = op;
        accel_cmd_hint   = hint;
        accel_cmd_id     = id;
        accel_cmd_data   = d;
        waits = 0;
        while (!accel_cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        acc_cyc = -1;
        if (!accel_cmd_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: op %h not accepted after %0d cycles", op, waits);
            accel_cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            model_cmd(op, hint, d, r, lat);
            exp_q.push_back('{id: id, data: r, cyc: cyc + lat - 1});
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        accel_cmd_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_b && accel_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp: id %h data %h with nothing outstanding",
                         accel_resp_id, accel_resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_id", 64'(accel_resp_id), 64'(e.id));
                chk("resp_data", accel_resp_data, e.data);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int a1, a2, w1, w2;
        logic [255:0] d;
        logic [4:0]   op;

        accel_cmd_valid  = 1'b0;
        accel_cmd_opcode = '0;
        accel_cmd_hint   = '0;
        accel_cmd_id     = '0;
        accel_cmd_data   = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(accel_cmd_ready), 64'd0);
        chk("rst_resp_valid", 64'(accel_resp_valid), 64'd0);
        chk("rst_resp_id", 64'(accel_resp_id), 64'd0);
        chk("rst_resp_data", accel_resp_data, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(accel_cmd_ready), 64'd1);

        // NOP then read the completion counter.
        send(5'h00, 8'h00, 12'h005, '0, a1, w1);
        send(5'h02, 8'h07, 12'h006, '0, a2, w2);
        idle(2);

        // Back-to-back write/read of csr[2].
        send(5'h01, 8'h02, 12'h010, 256'h1234, a1, w1);
        send(5'h02, 8'h02, 12'h011, '0, a2, w2);
        chk("wr_rd_b2b_gap", 64'(a2 - a1), 64'd1);
        chk("wr_rd_b2b_wait", 64'(w2), 64'd0);
        idle(2);

        // DOT8 2*3 over 16 lanes; ready low for four cycles.
        d = {{16{8'h03}}, {16{8'h02}}};
        send(5'h03, 8'h00, 12'hABC, d, a1, w1);
        @(negedge clk);
        accel_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dot_ready_low", 64'(accel_cmd_ready), 64'd0);
            @(negedge clk);
        end
        chk("dot_ready_back", 64'(accel_cmd_ready), 64'd1);

        // DOT8 -128*127 with a command held valid behind it.
        d = {{16{8'h7F}}, {16{8'h80}}};
        send(5'h03, 8'h00, 12'h123, d, a1, w1);
        send(5'h00, 8'h00, 12'h124, '0, a2, w2);
        chk("held_cmd_accept_gap", 64'(a2 - a1), 64'd5);

        // Unknown opcode and a write to the read-only counter.
        send(5'h1F, 8'h00, 12'h200, '0, a1, w1);
        send(5'h01, 8'h07, 12'h201, {8{32'hDEADBEEF}}, a1, w1);
        send(5'h02, 8'h07, 12'h202, '0, a1, w1);
        idle(2);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = 5'h00;
                1, 5: op = 5'h01;
                2: op = 5'h02;
                3: op = 5'h03;
                default: op = 5'($urandom_range(4, 31));
            endcase
            d = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            send(op, 8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)), d, a1, w1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        chk("queue_drained_pre_rst", 64'(exp_q.size()), 64'd0);

        // Reset during DOT at k==1 aborts the command.
        send(5'h03, 8'h00, 12'h3AA, {8{$urandom()}}, a1, w1);
        @(negedge clk);
        accel_cmd_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("abort_ready", 64'(accel_cmd_ready), 64'd0);
        chk("abort_resp_valid", 64'(accel_resp_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(accel_resp_valid), 64'd0);
        end
        rst_b = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 64'(accel_cmd_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            send(5'h02, 8'(i), 12'(12'h400 + i), '0, a1, w1);
        end
        idle(2);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
